// File: rtl/vram_pixel_writer_pkg.sv
// Shared VRAM word geometry and write-FIFO entry layout for the pixel writer and vram_display.
// The address packing here must stay in lockstep with the display's read side.
package vram_pixel_writer_pkg;

  localparam int VRAM_ADDR_W = 19;
  localparam int VRAM_DATA_W = 36;
  localparam int PIXEL_W     = 18;

  typedef struct packed {
    logic [1:0]             mask;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } wr_entry_t;

  // One ZBT word covers an even/odd pixel pair, so the address drops x[0].
  function automatic logic [VRAM_ADDR_W-1:0] pack_addr(input logic [9:0] y, input logic [9:0] x);
    return {y, x[9:1]};
  endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// Small write-word FIFO for the pixel writer: up to two pushes and one pop per cycle.
// Entry 0 is always written before entry 1 when both push in the same cycle.
module vram_write_fifo
  import vram_pixel_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push0,
  input  wr_entry_t              entry0,
  input  logic                   push1,
  input  wr_entry_t              entry1,
  input  logic                   pop,
  output wr_entry_t              head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  wr_entry_t        mem_q [DEPTH];
  wr_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_idx1;

  always_comb begin
    mem_d    = mem_q;
    wr_idx1  = push0 ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    if (push0) mem_d[wr_ptr_q] = entry0;
    if (push1) mem_d[wr_idx1]  = entry1;
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push0) + LVL_W'(push1) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/vram_pixel_writer.sv
// Packs a pixel stream into 36-bit VRAM pair words and writes them in bus slots
// left free by vram_display, buffering through a small FIFO.
module vram_pixel_writer
  import vram_pixel_writer_pkg::*;
#(
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  input  logic [10:0]                 pix_x,
  input  logic [9:0]                  pix_y,
  input  logic [PIXEL_W-1:0]          pix_data,
  input  logic                        frame_done,
  input  logic                        wr_slot,
  output logic                        vram_we,
  output logic [VRAM_ADDR_W-1:0]      vram_write_addr,
  output logic [VRAM_DATA_W-1:0]      vram_write_data,
  output logic [1:0]                  vram_we_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 drop_count
);

  localparam int IDLE_W = $clog2(HOLD_TIMEOUT) + 1;

  logic                   run_q, run_d;
  logic                   hold_v_q, hold_v_d;
  logic [VRAM_ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [PIXEL_W-1:0]     hold_data_q, hold_data_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [15:0]            drop_q, drop_d;
  logic                   we_q, we_d;
  logic [VRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [VRAM_DATA_W-1:0] data_q, data_d;
  logic [1:0]             mask_q, mask_d;

  logic                   acc, in_range, timeout_hit, flush_req, space_ok;
  logic [VRAM_ADDR_W-1:0] pix_addr;
  logic                   push0, push1, pop;
  wr_entry_t              e0, e1, head;
  logic [$clog2(FIFO_DEPTH):0] level;

  vram_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push0  (push0),
    .entry0 (e0),
    .push1  (push1),
    .entry1 (e1),
    .pop    (pop),
    .head   (head),
    .level  (level)
  );

  // Requiring two free entries lets any accepted pixel plus a flush land in one cycle.
  always_comb begin
    pix_ready   = run_q && (int'(level) <= FIFO_DEPTH - 2);
    acc         = pix_valid && pix_ready;
    in_range    = (int'(pix_x) < H_ACTIVE) && (int'(pix_y) < V_ACTIVE);
    pix_addr    = pack_addr(pix_y, pix_x[9:0]);
    timeout_hit = hold_v_q && !acc && (idle_q == IDLE_W'(HOLD_TIMEOUT - 1));
    flush_req   = frame_done || flush_pend_q || timeout_hit;
    space_ok    = acc || (int'(level) < FIFO_DEPTH);

    run_d       = 1'b1;
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    push0       = 1'b0;
    push1       = 1'b0;
    e0          = '0;
    e1          = '0;
    drop_d      = drop_q;

    if (acc && !in_range) begin
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end else if (acc && !pix_x[0]) begin
      if (hold_v_q) begin
        push0 = 1'b1;
        e0    = '{mask: 2'b10, addr: hold_addr_q, data: {hold_data_q, {PIXEL_W{1'b0}}}};
      end
      hold_v_d    = 1'b1;
      hold_addr_d = pix_addr;
      hold_data_d = pix_data;
    end else if (acc) begin
      if (hold_v_q && hold_addr_q == pix_addr) begin
        push0 = 1'b1;
        e0    = '{mask: 2'b11, addr: pix_addr, data: {hold_data_q, pix_data}};
      end else if (hold_v_q) begin
        push0 = 1'b1;
        e0    = '{mask: 2'b10, addr: hold_addr_q, data: {hold_data_q, {PIXEL_W{1'b0}}}};
        push1 = 1'b1;
        e1    = '{mask: 2'b01, addr: pix_addr, data: {{PIXEL_W{1'b0}}, pix_data}};
      end else begin
        push0 = 1'b1;
        e0    = '{mask: 2'b01, addr: pix_addr, data: {{PIXEL_W{1'b0}}, pix_data}};
      end
      hold_v_d = 1'b0;
    end

    // Flush whatever is still held after the pixel; a full FIFO defers it.
    if (flush_req && hold_v_d && space_ok) begin
      if (!push0) begin
        push0 = 1'b1;
        e0    = '{mask: 2'b10, addr: hold_addr_d, data: {hold_data_d, {PIXEL_W{1'b0}}}};
      end else begin
        push1 = 1'b1;
        e1    = '{mask: 2'b10, addr: hold_addr_d, data: {hold_data_d, {PIXEL_W{1'b0}}}};
      end
      hold_v_d = 1'b0;
    end
    flush_pend_d = (frame_done || flush_pend_q) && hold_v_d;

    if (!hold_v_d || acc)                           idle_d = '0;
    else if (idle_q != IDLE_W'(HOLD_TIMEOUT - 1))   idle_d = idle_q + IDLE_W'(1);
    else                                            idle_d = idle_q;

    pop    = wr_slot && (level != '0);
    we_d   = pop;
    addr_d = pop ? head.addr : addr_q;
    data_d = pop ? head.data : data_q;
    mask_d = pop ? head.mask : mask_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q        <= 1'b0;
      hold_v_q     <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      flush_pend_q <= 1'b0;
      idle_q       <= '0;
      drop_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
    end else begin
      run_q        <= run_d;
      hold_v_q     <= hold_v_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      flush_pend_q <= flush_pend_d;
      idle_q       <= idle_d;
      drop_q       <= drop_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
    end
  end

  assign vram_we         = we_q;
  assign vram_write_addr = addr_q;
  assign vram_write_data = data_q;
  assign vram_we_mask    = mask_q;
  assign fifo_level      = level;
  assign drop_count      = drop_q;

endmodule
